// File: rtl/word_uart_tx_param.sv
// Word-to-UART transmitter. It accepts a WORD_BYTES-byte word over valid/ready and sends it as
// WORD_BYTES back-to-back 8N1/8N2 frames, either least or most significant byte first.
module word_uart_tx_param #(
  parameter int CLKS_PER_BIT = 868,
  parameter int WORD_BYTES   = 4,
  parameter int MSB_FIRST    = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    word_valid,
  output logic                    word_ready,
  input  logic [8*WORD_BYTES-1:0] word_data,
  output logic                    tx,
  output logic                    busy,
  output logic                    word_done
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BYTE_W = $clog2(WORD_BYTES + 1);
  localparam int W      = 8 * WORD_BYTES;

  if (CLKS_PER_BIT < 2 || WORD_BYTES < 1 || (STOP_BITS != 1 && STOP_BITS != 2)) begin : g_param_check
    $error("word_uart_tx_param: illegal parameter set");
  end

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t            state, state_n;
  logic [BAUD_W-1:0] baud, baud_n;
  logic [2:0]        bit_cnt, bit_n;
  logic [BYTE_W-1:0] byte_cnt, byte_n;
  logic [W-1:0]      word_q, word_n;
  logic              tx_n, busy_n, ready_n, done_n;

  logic [BYTE_W-1:0] byte_idx;
  logic [7:0]        cur_byte;
  logic              baud_end, last_byte;

  // byte_cnt counts frames sent so far; byte_idx maps it onto the held word
  assign byte_idx  = (MSB_FIRST != 0) ? BYTE_W'(WORD_BYTES - 1) - byte_cnt : byte_cnt;
  assign cur_byte  = 8'(word_q >> {byte_idx, 3'b000});
  assign baud_end  = (baud == BAUD_W'(CLKS_PER_BIT - 1));
  assign last_byte = (byte_cnt == BYTE_W'(WORD_BYTES - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      baud       <= '0;
      bit_cnt    <= '0;
      byte_cnt   <= '0;
      word_q     <= '0;
      tx         <= 1'b1;
      busy       <= 1'b0;
      word_ready <= 1'b1;
      word_done  <= 1'b0;
    end else begin
      state      <= state_n;
      baud       <= baud_n;
      bit_cnt    <= bit_n;
      byte_cnt   <= byte_n;
      word_q     <= word_n;
      tx         <= tx_n;
      busy       <= busy_n;
      word_ready <= ready_n;
      word_done  <= done_n;
    end
  end

  // Outputs are computed one cycle early so tx/ready/busy/done come straight from flops
  always_comb begin
    state_n = state;
    baud_n  = baud;
    bit_n   = bit_cnt;
    byte_n  = byte_cnt;
    word_n  = word_q;
    tx_n    = tx;
    busy_n  = busy;
    ready_n = word_ready;
    done_n  = 1'b0;

    if (state != IDLE) baud_n = baud_end ? '0 : baud + 1'b1;

    case (state)
      IDLE: begin
        tx_n = 1'b1;
        if (word_valid && word_ready) begin
          state_n = START;
          word_n  = word_data;
          tx_n    = 1'b0;
          busy_n  = 1'b1;
          ready_n = 1'b0;
          baud_n  = '0;
          bit_n   = '0;
          byte_n  = '0;
        end
      end
      START: begin
        if (baud_end) begin
          state_n = DATA;
          bit_n   = '0;
          tx_n    = cur_byte[0];
        end
      end
      DATA: begin
        if (baud_end) begin
          if (bit_cnt == 3'd7) begin
            state_n = STOP;
            bit_n   = '0;
            tx_n    = 1'b1;
          end else begin
            bit_n = bit_cnt + 3'd1;
            tx_n  = cur_byte[bit_cnt + 3'd1];
          end
        end
      end
      STOP: begin
        // bit_cnt is reused to count stop bits
        if (baud_end) begin
          if (bit_cnt != 3'(STOP_BITS - 1)) begin
            bit_n = bit_cnt + 3'd1;
          end else if (!last_byte) begin
            state_n = START;
            bit_n   = '0;
            byte_n  = byte_cnt + 1'b1;
            tx_n    = 1'b0;
          end else begin
            state_n = IDLE;
            bit_n   = '0;
            byte_n  = '0;
            tx_n    = 1'b1;
            busy_n  = 1'b0;
            ready_n = 1'b1;
            done_n  = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_word_uart_tx_param.sv
// Directed bench for word_uart_tx_param: three parameter sets, with frames decoded from tx
// at bit centres and compared with hand-computed bytes and word_done offsets.
module tb_word_uart_tx_param;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  // A: C=4, 4 bytes, LSB first, 1 stop.  B: C=4, 4 bytes, MSB first, 2 stop.  C: C=2, 1 byte.
  logic        va, vb, vc;
  logic [31:0] da, db;
  logic [7:0]  dc;
  logic        ra, rb, rc, ta, tb, tc, ba, bb, bc, oa, ob, oc;

  word_uart_tx_param #(.CLKS_PER_BIT(4), .WORD_BYTES(4), .MSB_FIRST(0), .STOP_BITS(1)) u_a (
    .clk(clk), .reset_n(reset_n), .word_valid(va), .word_ready(ra), .word_data(da),
    .tx(ta), .busy(ba), .word_done(oa));
  word_uart_tx_param #(.CLKS_PER_BIT(4), .WORD_BYTES(4), .MSB_FIRST(1), .STOP_BITS(2)) u_b (
    .clk(clk), .reset_n(reset_n), .word_valid(vb), .word_ready(rb), .word_data(db),
    .tx(tb), .busy(bb), .word_done(ob));
  word_uart_tx_param #(.CLKS_PER_BIT(2), .WORD_BYTES(1), .MSB_FIRST(0), .STOP_BITS(1)) u_c (
    .clk(clk), .reset_n(reset_n), .word_valid(vc), .word_ready(rc), .word_data(dc),
    .tx(tc), .busy(bc), .word_done(oc));

  int   sel = 0;
  logic tx_m, busy_m, done_m, ready_m;
  always_comb begin
    case (sel)
      1:       begin tx_m = tb; busy_m = bb; done_m = ob; ready_m = rb; end
      2:       begin tx_m = tc; busy_m = bc; done_m = oc; ready_m = rc; end
      default: begin tx_m = ta; busy_m = ba; done_m = oa; ready_m = ra; end
    endcase
  end

  int n_chk = 0;
  int n_bad = 0;
  int acc_a = 0;
  always @(posedge clk) if (reset_n && va && ra) acc_a <= acc_a + 1;

  logic bits [0:599];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Called just after the accept edge; records tx until word_done, then decodes the frames.
  task automatic capture(input string tag, input int nb, input int c, input int sb,
                         input logic [31:0] exp);
    int done_t = -1;
    int flen = (9 + sb) * c;
    logic [7:0] by;
    for (int t = 0; t < 600; t++) begin
      @(negedge clk);
      bits[t] = tx_m;
      if (done_m) begin
        done_t = t;
        break;
      end
      chk({tag, "_busy"}, 32'(busy_m), 32'd1);
    end
    chk({tag, "_done_t"}, done_t, nb * flen);
    chk({tag, "_ready_at_done"}, 32'(ready_m), 32'd1);
    chk({tag, "_busy_at_done"}, 32'(busy_m), 32'd0);
    for (int f = 0; f < nb; f++) begin
      chk({tag, "_start"}, 32'(bits[f*flen + c/2]), 32'd0);
      for (int b = 0; b < 8; b++) by[b] = bits[f*flen + (b+1)*c + c/2];
      chk({tag, "_byte"}, 32'(by), 32'(exp[8*f +: 8]));
      for (int s = 0; s < sb; s++)
        chk({tag, "_stop"}, 32'(bits[f*flen + (9+s)*c + c/2]), 32'd1);
    end
  endtask

  initial begin
    logic [9:0] stream;
    int acc0;
    va = 1'b1; da = 32'hDEADBEEF;
    vb = 1'b0; db = '0;
    vc = 1'b0; dc = '0;

    // reset held with valid high
    repeat (3) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      chk("rst_tx", 32'(tx_m), 32'd1);
      chk("rst_ready", 32'(ready_m), 32'd1);
      chk("rst_busy", 32'(busy_m), 32'd0);
      chk("rst_done", 32'(done_m), 32'd0);
    end
    va = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    sel = 0;
    #1;
    chk("rst_no_accept_busy", 32'(busy_m), 32'd0);

    // LSB-first word
    @(negedge clk);
    sel = 0; va = 1'b1; da = 32'h12345678;
    #1 chk("t2_ready", 32'(ready_m), 32'd1);
    @(posedge clk);
    #1 va = 1'b0; da = 32'hFFFFFFFF;
    capture("t2", 4, 4, 1, 32'h12345678);
    for (int i = 0; i < 10; i++) stream[9-i] = bits[i*4 + 2];
    chk("t2_stream", 32'(stream), 32'(10'b0000111101));

    // MSB-first, two stop bits
    @(negedge clk);
    sel = 1; vb = 1'b1; db = 32'h12345678;
    #1 chk("t3_ready", 32'(ready_m), 32'd1);
    @(posedge clk);
    #1 vb = 1'b0;
    capture("t3", 4, 4, 2, 32'h78563412);

    // valid held high across two words
    @(negedge clk);
    acc0 = acc_a;
    sel = 0; va = 1'b1; da = 32'hAABBCCDD;
    @(posedge clk);
    #1 da = 32'h01020304;
    capture("t4a", 4, 4, 1, 32'hAABBCCDD);
    @(posedge clk);
    #1 va = 1'b0;
    capture("t4b", 4, 4, 1, 32'h01020304);
    chk("t4_nogap", 32'(bits[0]), 32'd0);
    chk("t4_accepts", acc_a - acc0, 32'd2);

    // async reset during DATA of byte 2 (bit 0 of 0x22 is low)
    @(negedge clk);
    sel = 0; va = 1'b1; da = 32'h11223344;
    @(posedge clk);
    #1 va = 1'b0;
    repeat (86) @(negedge clk);
    chk("t5_pre_tx", 32'(tx_m), 32'd0);
    reset_n = 1'b0;
    #1;
    chk("t5_rst_tx", 32'(tx_m), 32'd1);
    chk("t5_rst_busy", 32'(busy_m), 32'd0);
    chk("t5_rst_ready", 32'(ready_m), 32'd1);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    va = 1'b1; da = 32'hCAFEF00D;
    @(posedge clk);
    #1 va = 1'b0;
    capture("t5", 4, 4, 1, 32'hCAFEF00D);

    // single-byte variant, data changed mid-frame
    @(negedge clk);
    sel = 2; vc = 1'b1; dc = 8'hA5;
    @(posedge clk);
    #1 vc = 1'b0; dc = 8'h5A;
    capture("t6", 1, 2, 1, 32'h000000A5);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
